fx_rdbus: RTL

FX_RDBUS -- requirements
Module: fx_rdbus

---
 rtl/fx_rdbus.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fx_rdbus.sv
// fx_rdbus: single-outstanding read collector over NCH slave read-data channels.
// A read targets one channel, waits (bounded by TMO cycles) for that channel's
// valid flag, captures the data (own slice, or OR of all valid slices in MODE 1),
// and presents it for one cycle. Sticky flags report timeouts/bad selects and
// collisions (more than one channel valid in the capture cycle).
module fx_rdbus #(
    parameter int NCH  = 6,
    parameter int DW   = 8,
    parameter int TMO  = 16,
    parameter int MODE = 0
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [((($clog2(NCH)) < 1) ? 1 : $clog2(NCH))-1:0] rd_sel,
    input  logic [NCH*DW-1:0] fx_q_ch,
    input  logic [NCH-1:0]    fx_vld_ch,
    input  logic              err_clr,
    output logic [DW-1:0]     fx_q,
    output logic              fx_q_vld,
    output logic              busy,
    output logic              err_tmo,
    output logic              err_col
);

    localparam int SW = (($clog2(NCH)) < 1) ? 1 : $clog2(NCH);
    localparam logic [SW:0] NCH_LIM  = (SW+1)'(NCH);
    localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [NCH-1:0] v);
        logic [NCH-1:0] one;
        one = {{(NCH-1){1'b0}}, 1'b1};
        return |(v & (v - one));
    endfunction

    state_t          state_q;
    logic [SW-1:0]   sel_q;
    logic [7:0]      cnt_q;
    logic [DW-1:0]   data_q;
    logic            vld_q;
    logic            busy_q;
    logic            err_tmo_q;
    logic            err_col_q;
    logic            err_tmo_d;
    logic            err_col_d;

    logic            sel_ok_s;
    logic            sel_vld_s;
    logic [DW-1:0]   sel_dat_s;
    logic [DW-1:0]   or_dat_s;
    logic [DW-1:0]   cap_dat_s;
    logic            multi_vld_s;
    logic            req_bad_s;
    logic            cap_s;
    logic            tmo_hit_s;

    assign sel_ok_s = ({1'b0, rd_sel} < NCH_LIM);

    // Pick the selected channel's valid/data and build the OR-merge of valid slices.
    always_comb begin
        sel_vld_s = 1'b0;
        sel_dat_s = '0;
        or_dat_s  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q == SW'(i)) begin
                sel_vld_s = fx_vld_ch[i];
                sel_dat_s = fx_q_ch[i*DW +: DW];
            end else begin
                sel_vld_s = sel_vld_s;
                sel_dat_s = sel_dat_s;
            end
            if (fx_vld_ch[i]) begin
                or_dat_s = or_dat_s | fx_q_ch[i*DW +: DW];
            end else begin
                or_dat_s = or_dat_s;
            end
        end
        multi_vld_s = multi_hot(fx_vld_ch);
        if (MODE == 1) begin
            cap_dat_s = or_dat_s;
        end else begin
            cap_dat_s = sel_dat_s;
        end
    end

    // Decode the per-cycle events and the next value of the sticky flags (set beats clear).
    always_comb begin
        req_bad_s = 1'b0;
        cap_s     = 1'b0;
        tmo_hit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_bad_s = rd_req & ~sel_ok_s;
            end
            ST_WAIT: begin
                cap_s     = sel_vld_s;
                tmo_hit_s = ~sel_vld_s & (cnt_q == TMO_LAST);
            end
            default: begin
                req_bad_s = 1'b0;
            end
        endcase
        err_tmo_d = req_bad_s | tmo_hit_s | (err_tmo_q & ~err_clr);
        err_col_d = (cap_s & multi_vld_s) | (err_col_q & ~err_clr);
    end

    // Read FSM with registered data, strobe, busy and error flags.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= 8'd0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_tmo_q <= 1'b0;
            err_col_q <= 1'b0;
        end else begin
            err_tmo_q <= err_tmo_d;
            err_col_q <= err_col_d;
            vld_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_req && sel_ok_s) begin
                        sel_q   <= rd_sel;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cap_s) begin
                        data_q  <= cap_dat_s;
                        vld_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (tmo_hit_s) begin
                        data_q  <= '0;
                        vld_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fx_q     = data_q;
    assign fx_q_vld = vld_q;
    assign busy     = busy_q;
    assign err_tmo  = err_tmo_q;
    assign err_col  = err_col_q;

endmodule
